// File: rtl/cdc_host_if.sv
// LC8951-compatible CDC host interface: CPU register port, multi-slot sector ring, byte transfer engine.
// Define CDC_CMD_EN to add the 4-deep COMIN command FIFO and its CMD_* stream port.
module cdc_host_if #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DBC_W = 12
) (
  input  logic          CLK_SYS,
  input  logic          RESET,
  input  logic          nWR,
  input  logic          nRD,
  input  logic          RS,
  input  logic [7:0]    DIN,
  output logic [7:0]    DOUT,
  input  logic [31:0]   HEAD_IN,
  input  logic          SECTOR_WR_DONE,
  output logic [AW-1:0] WA_OUT,
  output logic [AW-1:0] BUF_ADDR,
  output logic          BUF_RD,
  input  logic [7:0]    BUF_Q,
  output logic [7:0]    XFER_DATA,
  output logic          XFER_VALID,
  input  logic          XFER_READY,
  output logic          CDC_nIRQ,
  output logic          NEXT_SECTOR_REQ
`ifdef CDC_CMD_EN
  ,
  output logic [7:0]    CMD_DATA,
  output logic          CMD_VALID,
  input  logic          CMD_READY
`endif
);

  localparam int unsigned SectorBytes = 2352;
  localparam int unsigned RingBytes   = SLOTS * SectorBytes;
  localparam int unsigned OccW        = $clog2(SLOTS + 1);
  localparam logic [OccW-1:0] OccFull = OccW'(SLOTS);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StPres, StDone} xfer_state_e;
  xfer_state_e state_q, state_d;

  logic             nwr_q, nrd_q;
  logic [3:0]       ar_q;
  logic             cmdien_q, dteien_q, decien_q, douten_q, decen_q;
  logic [DBC_W-1:0] dbc_q;
  logic [AW-1:0]    dac_q, wa_q, pt_q;
  logic [31:0]      head_q;
  logic             dtei_q, deci_q, nvalst_q, req_pend_q;
  logic [OccW-1:0]  occ_q;
  logic [7:0]       data_q, dout_q;
  logic             nirq_q, nsr_q;

  logic        cmdi;
  logic [7:0]  sbout;
  logic        wr_edge, rd_edge, wr_ptr, rd_ptr;
  logic        we_dttrg, we_dtack, rd_stat3, sector_in;
  logic        accept, done, busy;
  logic [7:0]  rd_data;
  logic [15:0] dbc_ext, dac_ext, wa_ext, pt_ext;
  logic [31:0] wa_sum;
  logic [AW-1:0] wa_next;

  // Strobe falling edges; a coincident write suppresses the read.
  assign wr_edge   = nwr_q & ~nWR;
  assign rd_edge   = nrd_q & ~nRD & ~wr_edge;
  assign wr_ptr    = wr_edge & RS;
  assign rd_ptr    = rd_edge & RS;
  assign we_dttrg  = wr_ptr && (ar_q == 4'd6);
  assign we_dtack  = wr_ptr && (ar_q == 4'd7);
  assign rd_stat3  = rd_ptr && (ar_q == 4'd15);
  assign sector_in = SECTOR_WR_DONE & decen_q;
  assign busy      = (state_q != StIdle);

  assign dbc_ext = 16'(dbc_q);
  assign dac_ext = 16'(dac_q);
  assign wa_ext  = 16'(wa_q);
  assign pt_ext  = 16'(pt_q);
  assign wa_sum  = 32'(wa_q) + SectorBytes;
  assign wa_next = (wa_sum >= RingBytes) ? '0 : AW'(wa_sum);

  always_comb begin
    rd_data = 8'h00;
    if (!RS) begin
      rd_data = {4'h0, ar_q};
    end else begin
      case (ar_q)
        4'd0:    rd_data = sbout;
        4'd1:    rd_data = {~cmdi, ~dtei_q, ~deci_q, 1'b1, ~busy, 1'b1, ~busy, 1'b1};
        4'd2:    rd_data = dbc_ext[7:0];
        4'd3:    rd_data = {{4{dtei_q}}, dbc_ext[11:8]};
        4'd4:    rd_data = head_q[31:24];
        4'd5:    rd_data = head_q[23:16];
        4'd6:    rd_data = head_q[15:8];
        4'd7:    rd_data = head_q[7:0];
        4'd8:    rd_data = pt_ext[7:0];
        4'd9:    rd_data = pt_ext[15:8];
        4'd10:   rd_data = wa_ext[7:0];
        4'd11:   rd_data = wa_ext[15:8];
        4'd15:   rd_data = {nvalst_q, 7'b0};
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: if (we_dttrg && douten_q) state_d = StRd;
      StRd:   state_d = StWait;
      StWait: state_d = StPres;
      StPres: begin
        if (XFER_READY) begin
          accept  = 1'b1;
          state_d = (dbc_q == '0) ? StDone : StRd;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      nwr_q      <= 1'b1;
      nrd_q      <= 1'b1;
      ar_q       <= 4'd0;
      cmdien_q   <= 1'b0;
      dteien_q   <= 1'b0;
      decien_q   <= 1'b0;
      douten_q   <= 1'b0;
      decen_q    <= 1'b0;
      dbc_q      <= '0;
      dac_q      <= '0;
      wa_q       <= '0;
      pt_q       <= AW'(4);
      head_q     <= '0;
      dtei_q     <= 1'b0;
      deci_q     <= 1'b0;
      nvalst_q   <= 1'b1;
      req_pend_q <= 1'b0;
      occ_q      <= '0;
      data_q     <= 8'h00;
      dout_q     <= 8'h00;
      nirq_q     <= 1'b1;
      nsr_q      <= 1'b0;
    end else begin
      nwr_q <= nWR;
      nrd_q <= nRD;
      nsr_q <= 1'b0;

      if (rd_edge) dout_q <= rd_data;

      if (wr_edge && !RS) ar_q <= DIN[3:0];
      else if ((wr_ptr || rd_ptr) && ar_q != 4'd0) ar_q <= ar_q + 4'd1;

      if (wr_ptr) begin
        case (ar_q)
          4'd1: begin
            cmdien_q <= DIN[7];
            dteien_q <= DIN[6];
            decien_q <= DIN[5];
            douten_q <= DIN[1];
          end
          4'd2:    dbc_q   <= DBC_W'({dbc_ext[15:8], DIN});
          4'd3:    dbc_q   <= DBC_W'({DIN, dbc_ext[7:0]});
          4'd4:    dac_q   <= AW'({dac_ext[15:8], DIN});
          4'd5:    dac_q   <= AW'({DIN, dac_ext[7:0]});
          4'd8:    wa_q    <= AW'({wa_ext[15:8], DIN});
          4'd9:    wa_q    <= AW'({DIN, wa_ext[7:0]});
          4'd10:   decen_q <= DIN[7];
          default: ;
        endcase
      end

      if (sector_in) begin
        head_q <= HEAD_IN;
        pt_q   <= wa_q + AW'(4);
        wa_q   <= wa_next;
      end

      if (state_q == StWait) data_q <= BUF_Q;
      if (accept) begin
        dac_q <= dac_q + AW'(1);
        if (dbc_q != '0) dbc_q <= dbc_q - DBC_W'(1);
      end

      // Setting a flag always beats the CPU clearing it in the same cycle.
      if (done)          dtei_q <= 1'b1;
      else if (we_dtack) dtei_q <= 1'b0;

      if (sector_in) begin
        deci_q   <= 1'b1;
        nvalst_q <= 1'b0;
      end else if (rd_stat3) begin
        deci_q   <= 1'b0;
        nvalst_q <= 1'b1;
      end

      case ({sector_in && (occ_q != OccFull), done && (occ_q != '0)})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: ;
      endcase

      // A STAT3 read with the ring full defers the request until a slot frees.
      if (rd_stat3) begin
        if (occ_q < OccFull) nsr_q      <= 1'b1;
        else                 req_pend_q <= 1'b1;
      end else if (req_pend_q && occ_q < OccFull) begin
        nsr_q      <= 1'b1;
        req_pend_q <= 1'b0;
      end

      nirq_q <= ~|{cmdi & cmdien_q, dtei_q & dteien_q, deci_q & decien_q};
    end
  end

`ifdef CDC_CMD_EN
  logic [7:0] fifo_q [4];
  logic [1:0] fifo_rd_q;
  logic [2:0] fifo_cnt_q;
  logic       ncmdbrk_q;
  logic       push, pop;

  assign push      = wr_ptr && (ar_q == 4'd0) && (fifo_cnt_q != 3'd4);
  assign pop       = CMD_VALID && CMD_READY;
  assign CMD_VALID = (fifo_cnt_q != 3'd0);
  assign CMD_DATA  = fifo_q[fifo_rd_q];
  assign cmdi      = CMD_VALID;
  assign sbout     = CMD_DATA;

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      fifo_rd_q  <= 2'd0;
      fifo_cnt_q <= 3'd0;
      ncmdbrk_q  <= 1'b0;
    end else begin
      if (wr_ptr && ar_q == 4'd1) ncmdbrk_q <= DIN[4];
      if (!ncmdbrk_q) begin
        fifo_rd_q  <= 2'd0;
        fifo_cnt_q <= 3'd0;
      end else begin
        if (push) fifo_q[fifo_rd_q + fifo_cnt_q[1:0]] <= DIN;
        if (pop)  fifo_rd_q <= fifo_rd_q + 2'd1;
        fifo_cnt_q <= fifo_cnt_q + 3'(push) - 3'(pop);
      end
    end
  end
`else
  assign cmdi  = 1'b0;
  assign sbout = 8'h00;
`endif

  assign DOUT            = dout_q;
  assign WA_OUT          = wa_q;
  assign BUF_ADDR        = dac_q;
  assign BUF_RD          = (state_q == StRd);
  assign XFER_DATA       = data_q;
  assign XFER_VALID      = (state_q == StPres);
  assign CDC_nIRQ        = nirq_q;
  assign NEXT_SECTOR_REQ = nsr_q;

endmodule

// File: tb/tb_cdc_host_if.sv
// Self-checking bench for cdc_host_if: register port, sector ring bookkeeping, transfer engine.
// Randomised transfers are checked against a queue-based model of the byte stream.
module tb_cdc_host_if;
  localparam int SLOTS = 4;

  logic        clk = 1'b0;
  logic        reset, nwr, nrd, rs, swd;
  logic [7:0]  din, dout, xfer_data;
  logic [31:0] head_in;
  logic [15:0] wa_out, buf_addr;
  logic        buf_rd, xfer_valid, nirq, nsr;
  logic [7:0]  buf_q = 8'h00;
  logic        xfer_ready = 1'b0;
`ifdef CDC_CMD_EN
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_log[$];
`endif

  cdc_host_if #(.SLOTS(SLOTS), .AW(16), .DBC_W(12)) dut (
    .CLK_SYS(clk), .RESET(reset), .nWR(nwr), .nRD(nrd), .RS(rs), .DIN(din), .DOUT(dout),
    .HEAD_IN(head_in), .SECTOR_WR_DONE(swd), .WA_OUT(wa_out), .BUF_ADDR(buf_addr),
    .BUF_RD(buf_rd), .BUF_Q(buf_q), .XFER_DATA(xfer_data), .XFER_VALID(xfer_valid),
    .XFER_READY(xfer_ready), .CDC_nIRQ(nirq), .NEXT_SECTOR_REQ(nsr)
`ifdef CDC_CMD_EN
    , .CMD_DATA(cmd_data), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: ready toggles every cycle, 1: random
  int nsr_cnt = 0;
  logic [15:0] addr_log[$];
  logic [7:0]  data_log[$];

  // Model state
  int          m_wa, m_pt, m_occ, m_pend, m_decen;
  logic [31:0] m_head;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return 8'(a * 16'd7) ^ a[15:8] ^ 8'h5A;
  endfunction

  // Cache RAM, sink and request monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rdy_mode == 0) xfer_ready = ~xfer_ready;
    else               xfer_ready = 1'($urandom_range(0, 1));
    if (xfer_valid && xfer_ready) data_log.push_back(xfer_data);
    if (buf_rd) begin
      addr_log.push_back(buf_addr);
      buf_q = mem_byte(buf_addr);
    end
    if (nsr) nsr_cnt++;
`ifdef CDC_CMD_EN
    if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_data);
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [3:0] r, input logic [7:0] d);
    rs = 1'b0; din = {4'h0, r}; nwr = 1'b0; cyc(1); nwr = 1'b1; cyc(1);
    rs = 1'b1; din = d;         nwr = 1'b0; cyc(1); nwr = 1'b1; cyc(1);
  endtask

  task automatic cpu_rd(input logic [3:0] r, output logic [7:0] d);
    rs = 1'b0; din = {4'h0, r}; nwr = 1'b0; cyc(1); nwr = 1'b1; cyc(1);
    rs = 1'b1; nrd = 1'b0; cyc(1); d = dout; nrd = 1'b1; cyc(1);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] r, input logic [7:0] exp);
    logic [7:0] d;
    cpu_rd(r, d);
    check_eq(tag, d, exp);
  endtask

  task automatic sector(input logic [31:0] h);
    head_in = h; swd = 1'b1; cyc(1); swd = 1'b0;
    if (m_decen != 0) begin
      m_head = h;
      m_pt   = m_wa + 4;
      m_wa   = (m_wa + 2352 >= SLOTS * 2352) ? 0 : m_wa + 2352;
      if (m_occ < SLOTS) m_occ++;
    end
  endtask

  task automatic stat3(input string tag);
    int base;
    logic [7:0] d;
    base = nsr_cnt;
    cpu_rd(4'd15, d);
    check_eq({tag, "_stat3"}, d, 8'h00);
    cyc(3);
    if (m_occ < SLOTS) check_eq({tag, "_nsr"}, nsr_cnt - base, 1);
    else begin
      m_pend = 1;
      cyc(8);
      check_eq({tag, "_nsr_held"}, nsr_cnt - base, 0);
    end
  endtask

  task automatic run_xfer(input logic [15:0] dbc, input logic [15:0] dac, input int mode,
                          input bit retrig, input string tag);
    int a0, d0, n, bad, nbase;
    logic [15:0] ea;
    rdy_mode = mode;
    a0 = addr_log.size(); d0 = data_log.size(); nbase = nsr_cnt;
    cpu_wr(4'd2, dbc[7:0]); cpu_wr(4'd3, dbc[15:8]);
    cpu_wr(4'd4, dac[7:0]); cpu_wr(4'd5, dac[15:8]);
    cpu_wr(4'd6, 8'h00);
    n = 0;
    if (retrig) begin
      while (data_log.size() - d0 < 3 && n < 200) begin cyc(1); n++; end
      cpu_wr(4'd6, 8'h00);
    end
    while (data_log.size() - d0 < int'(dbc) + 1 && n < (int'(dbc) + 1) * 16 + 200) begin
      cyc(1); n++;
    end
    cyc(6);
    check_eq({tag, "_bytes"}, data_log.size() - d0, int'(dbc) + 1);
    check_eq({tag, "_reads"}, addr_log.size() - a0, int'(dbc) + 1);
    bad = 0;
    for (int i = 0; i <= int'(dbc); i++) begin
      ea = dac + 16'(i);
      if (a0 + i >= addr_log.size() || d0 + i >= data_log.size()) bad++;
      else if (addr_log[a0 + i] !== ea || data_log[d0 + i] !== mem_byte(ea)) bad++;
    end
    check_eq({tag, "_stream"}, bad, 0);
    if (m_occ > 0) m_occ--;
    check_eq({tag, "_nsr"}, nsr_cnt - nbase, m_pend);
    m_pend = 0;
    rd_check({tag, "_dbch"}, 4'd3, 8'hF0);
    rd_check({tag, "_ifstat_dtei"}, 4'd1, 8'hBF);
    cpu_wr(4'd7, 8'h00);
    rd_check({tag, "_ifstat_ack"}, 4'd1, 8'hFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h;
    int d0, n;
    reset = 1'b1; nwr = 1'b1; nrd = 1'b1; rs = 1'b0; din = 8'h00; swd = 1'b0; head_in = '0;
`ifdef CDC_CMD_EN
    cmd_ready = 1'b0;
`endif
    m_wa = 0; m_pt = 4; m_occ = 0; m_pend = 0; m_decen = 0; m_head = '0;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // Reset state
    check_eq("rst_nirq", nirq, 1);
    check_eq("rst_wa", wa_out, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", xfer_valid, 0);
    check_eq("rst_bufrd", buf_rd, 0);
    check_eq("rst_nsr", nsr, 0);
    rd_check("rst_ifstat", 4'd1, 8'hFF);
    rd_check("rst_ptl", 4'd8, 8'h04);
    rd_check("rst_pth", 4'd9, 8'h00);

    // Sector with DECEN clear is ignored
    sector(32'hDEADBEEF);
    cyc(2);
    check_eq("nodec_wa", wa_out, m_wa);
    check_eq("nodec_nirq", nirq, 1);

    // First sector: DECI interrupt, header, PT/WA
    cpu_wr(4'd10, 8'h80); m_decen = 1;
    cpu_wr(4'd1, 8'h22);
    sector(32'h0002_1000);
    cyc(1);
    check_eq("deci_irq", nirq, 0);
    rd_check("head0", 4'd4, 8'h00);
    rd_check("head1", 4'd5, 8'h02);
    rd_check("head2", 4'd6, 8'h10);
    rd_check("head3", 4'd7, 8'h00);
    rd_check("pt_l", 4'd8, 8'(m_pt));
    rd_check("pt_h", 4'd9, 8'(m_pt >> 8));
    check_eq("wa_1", wa_out, 16'h0930);
    stat3("s1");
    cyc(2);
    check_eq("irq_clear", nirq, 1);

    // 2048-byte transfer from 0x0004 with ready toggling
    run_xfer(16'h07FF, 16'h0004, 0, 1'b0, "big");

    // Fill the ring; the STAT3 read at full occupancy defers its request
    for (int s = 0; s < SLOTS; s++) begin
      h = $urandom;
      sector(h);
      cyc(1);
      check_eq($sformatf("wa_s%0d", s), wa_out, m_wa);
      rd_check($sformatf("head0_s%0d", s), 4'd4, m_head[31:24]);
      rd_check($sformatf("head3_s%0d", s), 4'd7, m_head[7:0]);
      rd_check($sformatf("walo_s%0d", s), 4'd10, 8'(m_wa));
      stat3($sformatf("s%0d", s + 2));
    end
    run_xfer(16'($urandom_range(0, 30)), 16'($urandom), 1, 1'b0, "rnd0");

    // Randomised transfers including DAC wrap
    run_xfer(16'd7, 16'hFFFC, 1, 1'b0, "wrap");
    for (int k = 0; k < 3; k++)
      run_xfer(16'($urandom_range(0, 60)), 16'($urandom), 1, 1'b0, $sformatf("rnd%0d", k + 1));

    // DTTRG while busy is ignored
    run_xfer(16'd20, 16'h0100, 0, 1'b1, "retrig");
    d0 = data_log.size();
    cyc(40);
    check_eq("retrig_quiet", data_log.size() - d0, 0);

    // RESET mid-transfer aborts with no DTEI
    rdy_mode = 0;
    cpu_wr(4'd2, 8'd100); cpu_wr(4'd3, 8'h00);
    cpu_wr(4'd4, 8'h40);  cpu_wr(4'd5, 8'h00);
    d0 = data_log.size();
    cpu_wr(4'd6, 8'h00);
    n = 0;
    while (data_log.size() - d0 < 5 && n < 200) begin cyc(1); n++; end
    check_eq("abort_started", (data_log.size() - d0 >= 5) ? 1 : 0, 1);
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    check_eq("abort_valid", xfer_valid, 0);
    check_eq("abort_dac", buf_addr, 0);
    check_eq("abort_nirq", nirq, 1);
    d0 = data_log.size();
    rd_check("abort_ifstat", 4'd1, 8'hFF);
    cyc(20);
    check_eq("abort_quiet", data_log.size() - d0, 0);

`ifdef CDC_CMD_EN
    // Command FIFO: fifth push is dropped, SBOUT peeks the head
    cpu_wr(4'd1, 8'h12);
    for (int c = 0; c < 5; c++) cpu_wr(4'd0, 8'(8'h11 + c));
    rd_check("cmd_ifstat", 4'd1, 8'h7F);
    rd_check("cmd_sbout", 4'd0, 8'h11);
    d0 = cmd_log.size();
    cmd_ready = 1'b1;
    cyc(10);
    check_eq("cmd_count", cmd_log.size() - d0, 4);
    for (int c = 0; c < 4; c++)
      if (d0 + c < cmd_log.size())
        check_eq($sformatf("cmd_byte%0d", c), cmd_log[d0 + c], 8'(8'h11 + c));
    rd_check("cmd_empty", 4'd1, 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_host_if.md
Name: cdc_host_if

Overview:
- Parametrised successor to the Neo CD LC8951 host-interface emulation, sitting between the 68k CDC register port and the CD sector cache RAM.
- Adds multi-slot sector buffering with real WA/PT tracking and a byte-stream transfer engine driven by DBC/DAC.
- Header bytes are latched from the HPS per sector.
- Register map, IRQ behaviour and STAT3 handshake stay compatible with the system ROM.

Parameters:
- SLOTS, 4, number of 2352-byte sector slots in cache RAM (1..8).
- AW, 16, cache address width; DAC/WA/PT width (AW >= ceil(log2(SLOTS*2352))).
- DBC_W, 12, byte-counter width.

Ports:
- CLK_SYS  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- nWR  in  1  CPU write strobe, active low
- nRD  in  1  CPU read strobe, active low
- RS  in  1  0 = address register, 1 = pointed register
- DIN  in  8  CPU write data
- DOUT  out  8  CPU read data
- HEAD_IN  in  32  {M,S,F,mode} header of the sector just written
- SECTOR_WR_DONE  in  1  one-cycle pulse: HPS finished writing the slot at WA_OUT
- WA_OUT  out  AW  cache base address for the next incoming sector
- BUF_ADDR  out  AW  cache read address
- BUF_RD  out  1  cache read strobe; BUF_Q is valid the following cycle
- BUF_Q  in  8  cache read data
- XFER_DATA  out  8  transfer byte
- XFER_VALID  out  1  transfer byte valid
- XFER_READY  in  1  destination accepts the byte
- CDC_nIRQ  out  1  interrupt, active low
- NEXT_SECTOR_REQ  out  1  one-cycle pulse requesting the next sector from the HPS

Behaviour:
- Single clock domain CLK_SYS. RESET is synchronous and active-high.
- Reset values:
  - DOUT=0, CDC_nIRQ=1, NEXT_SECTOR_REQ=0, XFER_VALID=0, BUF_RD=0.
  - WA_OUT=0, BUF_ADDR=0.
  - AR=0, DBC=0, DAC=0, PT=4, HEAD=0.
  - All flags and enables cleared; occupancy OCC=0; transfer FSM in IDLE.
- Any RESET mid-transfer aborts immediately with no DTEI.
- CPU access:
  - nWR/nRD are sampled each cycle; the action fires on the falling edge (prev=1, now=0).
  - RS=0 write: AR<=DIN[3:0]. RS=0 read: DOUT={4'h0,AR}.
  - RS=1 access: operates on register AR, then AR increments (4-bit wrap) when AR != 0.
  - If the write and read edges coincide, the write wins.
- Write map:
  - 0 COMIN.
  - 1 IFCTRL {CMDIEN,DTEIEN,DECIEN,nCMDBRK,nDTWAI,nSTWAI,DOUTEN,SOUTEN}.
  - 2/3 DBC L/H (H uses DBC_W-8 low bits).
  - 4/5 DAC L/H.
  - 6 DTTRG.
  - 7 DTACK (clears DTEI).
  - 8/9 WA L/H.
  - 10 CTRL0.
  - 11 CTRL1.
  - 12-15 ignored.
- Read map:
  - 0 SBOUT=0.
  - 1 IFSTAT {~CMDI,~DTEI,~DECI,1,~busy,1,~busy,1}.
  - 2 DBCL; 3 {{4{DTEI}},DBC[11:8]}.
  - 4-7 HEAD0..3.
  - 8/9 PT L/H; 10/11 WA L/H.
  - 12-14 STAT0..2=0.
  - 15 STAT3 {nVALST,7'b0}.
- STAT3 read: clears DECI and sets nVALST=1. It also issues NEXT_SECTOR_REQ if OCC<SLOTS; otherwise a pending flag is set and the request issues one cycle after OCC drops below SLOTS.
- Sector arrival, on SECTOR_WR_DONE with DECEN=1:
  - HEAD<=HEAD_IN bytes, M in HEAD0.
  - PT<=WA+4.
  - WA<=WA+2352, wrapping to 0 when the result reaches SLOTS*2352.
  - OCC+1, saturating at SLOTS.
  - DECI=1, nVALST=0.
- SECTOR_WR_DONE with DECEN=0 is ignored.
- Transfer FSM: IDLE -> RD -> WAIT -> PRES -> RD | DONE -> IDLE.
  - IDLE: a DTTRG write with DOUTEN=1 latches busy and enters RD. DTTRG while busy is ignored.
  - RD: BUF_RD=1, BUF_ADDR=DAC for exactly one cycle.
  - WAIT: capture BUF_Q.
  - PRES: XFER_VALID=1 held until XFER_READY. On accept, DAC+1 (AW wrap). If DBC==0, go to DONE; else DBC-1 and go to RD.
  - A DTTRG with DBC=N transfers exactly N+1 bytes.
  - DONE: DTEI=1, busy=0, OCC-1 (floor 0), back to IDLE.
- Flag precedence:
  - DTEI set and a DTACK write in the same cycle: set wins.
  - DECI set and a STAT3 read in the same cycle: set wins, nVALST=0.
- CDC_nIRQ is registered: ~|{CMDI&CMDIEN, DTEI&DTEIEN, DECI&DECIEN}, one cycle of latency.

Optional Feature:
- Macro: CDC_CMD_EN.
- Defined:
  - Adds a 4-deep command FIFO plus ports CMD_DATA out 8, CMD_VALID out 1, CMD_READY in 1.
  - A COMIN write pushes DIN; a push when full is dropped.
  - CMDI=1 while the FIFO is non-empty.
  - SBOUT reads return the FIFO head without popping. A CMD_VALID&CMD_READY handshake pops.
  - nCMDBRK=0 flushes the FIFO.
- Undefined: COMIN writes are ignored, CMDI is constant 0, and there are no extra ports.

Test Plan:
- Reset, then read reg 1 and reg 8/9 -> IFSTAT=8'hFF, PT=0x0004, CDC_nIRQ=1, WA_OUT=0.
- CTRL0=0x80, IFCTRL=0x22, pulse SECTOR_WR_DONE with HEAD_IN=0x00021000 -> next cycle CDC_nIRQ=0. HEAD reads 00,02,10,00. PT=0x0004, WA_OUT=0x0930. STAT3 read returns 0x00, then NEXT_SECTOR_REQ pulses once and CDC_nIRQ returns to 1.
- DBC=0x7FF, DAC=0x0004, DTTRG with XFER_READY toggling every other cycle -> exactly 2048 bytes, BUF_ADDR 0x0004..0x0803. DTEI set, DBCH reads 0xF0. DTACK write clears DTEI.
- SLOTS=4: four sectors with no transfer -> WA_OUT wraps to 0. Fifth STAT3 read gives no NEXT_SECTOR_REQ until a transfer completes, then exactly one pulse.
- DTTRG during an active transfer, and RESET asserted mid-transfer -> the second trigger is ignored. After reset XFER_VALID=0, DTEI=0, DAC=0.
- With CDC_CMD_EN: 5 COMIN writes 0x11..0x15 with CMD_READY=0 -> CMDI=1, SBOUT reads 0x11. After draining, 4 bytes are delivered and 0x15 is dropped.
